// File: rtl/datapath_control_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: sequences fetch/decode/execute/writeback,
// drives the load/tristate/regfile/ALU strobes and handshakes with memory.
module datapath_control_fsm #(
    parameter int WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ir_op,
    input  logic       zin,
    input  logic       sin,
    input  logic       mem_ready,
    output logic       lmar,
    output logic       lpc,
    output logic       lir,
    output logic       lmdr,
    output logic       ldx,
    output logic       ldy,
    output logic       lt,
    output logic       tpc,
    output logic       tt,
    output logic       tmdr2x,
    output logic       wrr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [2:0] fnsel,
    output logic       retire,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_M,
        S_FETCH_I,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_LD_A,
        S_LD_M,
        S_LD_W,
        S_ST_A,
        S_ST_M,
        S_BR,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [2:0] FN_PASS_X = 3'b010;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       br_taken;
    logic       taken_nxt;
    logic       fault_q;
    logic       in_mem;
    logic       timeout;

    assign in_mem  = (state == S_FETCH_M) || (state == S_LD_M) || (state == S_ST_M);
    // A ready on the last allowed cycle still completes; only a miss there faults.
    assign timeout = in_mem && !mem_ready && (wait_cnt == 8'(WAIT_MAX - 1));

    always_comb begin
        taken_nxt = 1'b0;
        case (ir_op)
            4'b1010: taken_nxt = zin;
            4'b1011: taken_nxt = sin;
            4'b1100: taken_nxt = 1'b1;
            default: taken_nxt = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            br_taken <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!in_mem) begin
                wait_cnt <= '0;
            end else if (!mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == S_DECODE) begin
                br_taken <= taken_nxt;
            end
            if (state_nxt == S_FAULT) begin
                fault_q <= 1'b1;
            end
        end
    end

    // NOTE: defaults assigned first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = S_FETCH_A;
            S_FETCH_A: state_nxt = S_FETCH_M;
            S_FETCH_M: begin
                if (mem_ready)    state_nxt = S_FETCH_I;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_FETCH_I: state_nxt = S_DECODE;
            S_DECODE: begin
                if (!ir_op[3]) begin
                    state_nxt = S_EXEC;
                end else begin
                    case (ir_op[2:0])
                        3'b000:                 state_nxt = S_LD_A;
                        3'b001:                 state_nxt = S_ST_A;
                        3'b010, 3'b011, 3'b100: state_nxt = S_BR;
                        3'b111:                 state_nxt = S_HALT;
                        default:                state_nxt = S_FETCH_A;
                    endcase
                end
            end
            S_EXEC:    state_nxt = S_WB;
            S_WB:      state_nxt = S_FETCH_A;
            S_LD_A:    state_nxt = S_LD_M;
            S_LD_M: begin
                if (mem_ready)    state_nxt = S_LD_W;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_LD_W:    state_nxt = S_FETCH_A;
            S_ST_A:    state_nxt = S_ST_M;
            S_ST_M: begin
                if (mem_ready)    state_nxt = S_FETCH_A;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_BR:      state_nxt = S_FETCH_A;
            S_HALT:    state_nxt = S_HALT;
            S_FAULT:   state_nxt = S_FAULT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        lmar   = 1'b0;
        lpc    = 1'b0;
        lir    = 1'b0;
        lmdr   = 1'b0;
        ldx    = 1'b0;
        ldy    = 1'b0;
        lt     = 1'b0;
        tpc    = 1'b0;
        tt     = 1'b0;
        tmdr2x = 1'b0;
        wrr    = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        fnsel  = 3'b000;
        retire = 1'b0;
        halted = 1'b0;
        // Reset blanks every strobe immediately, not only after the edge.
        if (!rst) begin
            case (state)
                S_FETCH_A: begin
                    tpc  = 1'b1;
                    lmar = 1'b1;
                end
                S_FETCH_M, S_LD_M: begin
                    mem_rd = 1'b1;
                    lmdr   = 1'b1;
                end
                S_FETCH_I: begin
                    tmdr2x = 1'b1;
                    lir    = 1'b1;
                    lpc    = 1'b1;
                end
                S_DECODE: begin
                    ldx    = 1'b1;
                    ldy    = 1'b1;
                    retire = (ir_op == 4'b1101) || (ir_op == 4'b1110);
                end
                S_EXEC: begin
                    lt    = 1'b1;
                    fnsel = ir_op[2:0];
                end
                S_WB: begin
                    tt     = 1'b1;
                    wrr    = 1'b1;
                    retire = 1'b1;
                end
                S_LD_A: begin
                    lmar  = 1'b1;
                    fnsel = FN_PASS_X;
                end
                S_LD_W: begin
                    tmdr2x = 1'b1;
                    wrr    = 1'b1;
                    retire = 1'b1;
                end
                S_ST_A: begin
                    lmar  = 1'b1;
                    lmdr  = 1'b1;
                    fnsel = FN_PASS_X;
                end
                S_ST_M: begin
                    mem_wr = 1'b1;
                    retire = mem_ready;
                end
                S_BR: begin
                    lpc    = br_taken;
                    retire = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign fault = fault_q & ~rst;

endmodule
